// File: rtl/cpc_int_gen_if.sv
// CPU-side bus of the raster interrupt generator:
// gate-array/PRI writes, Z80 acknowledge and the interrupt request.
interface cpc_int_gen_if #(
  parameter int LINE_W = 8
);
  logic [7:0]        D;
  logic              WE;
  logic              PRI_WE;
  logic [LINE_W-1:0] PRI_D;
  logic              INTack;
  logic              INT;
  logic              INT_SRC;

  modport master (
    output D, WE, PRI_WE, PRI_D, INTack,
    input  INT, INT_SRC
  );

  modport slave (
    input  D, WE, PRI_WE, PRI_D, INTack,
    output INT, INT_SRC
  );
endinterface

// File: rtl/cpc_int_gen.sv
// CPC raster interrupt generator: periodic HSYNC-count IRQ with VSYNC resync.
// Define CPC_INT_PRI_EN to add the programmable raster interrupt (PRI).
module cpc_int_gen #(
  parameter int LINES_PER_INT = 52,
  parameter int CNT_W         = 6,
  parameter int SYNC_DELAY    = 2,
  parameter int LINE_W        = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             crtc_hs,
  input  logic             crtc_vs,
  cpc_int_gen_if.slave     bus,
  output logic [CNT_W-1:0] line_cnt
);

  localparam logic [CNT_W-1:0] LPI = CNT_W'(LINES_PER_INT);
  localparam logic [1:0]       SD  = 2'(SYNC_DELAY);

  logic             old_hs, old_vs;
  logic             hf, vr;
  logic             int_q, int_n;
  logic             src_q, src_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [1:0]       sync_q, sync_n;
  logic             ga_cmd;
  logic             pri_on;
  logic             line_hit;

  assign hf = old_hs & ~crtc_hs;
  assign vr = ~old_vs & crtc_vs;

  assign ga_cmd = bus.WE
                & (bus.D[7:6] == 2'b10)
                & bus.D[4];

`ifdef CPC_INT_PRI_EN
  logic [LINE_W-1:0] pri_q;
  logic [LINE_W-1:0] line_q, line_inc;
  logic              unused_d;

  assign unused_d = ^{bus.D[5], bus.D[3:0]};

  assign line_inc = &line_q ? line_q
                            : line_q + 1'b1;
  assign pri_on   = |pri_q;
  assign line_hit = hf & pri_on
                  & (line_inc == pri_q);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pri_q  <= '0;
      line_q <= '0;
    end else begin
      if (bus.PRI_WE)
        pri_q <= bus.PRI_D;
      // VR wins over HF: the line is counted first, then restarted
      if (vr)
        line_q <= '0;
      else if (hf)
        line_q <= line_inc;
    end
  end
`else
  logic unused_d;

  assign unused_d = ^{bus.D[5], bus.D[3:0],
                      bus.PRI_WE, bus.PRI_D};
  assign pri_on   = 1'b0;
  assign line_hit = 1'b0;
`endif

  always_comb begin
    int_n  = int_q;
    src_n  = src_q;
    cnt_n  = cnt_q;
    sync_n = sync_q;

    if (bus.INTack) begin
      int_n = 1'b0;
      if (!src_q)
        cnt_n[CNT_W-1] = 1'b0;
    end

    if (ga_cmd) begin
      cnt_n = '0;
      int_n = 1'b0;
    end

    if (hf) begin
      cnt_n = cnt_n + 1'b1;
      if (cnt_n == LPI) begin
        cnt_n = '0;
        if (!pri_on && !int_n) begin
          int_n = 1'b1;
          src_n = 1'b0;
        end
      end

      if (sync_q < SD) begin
        sync_n = sync_q + 2'd1;
        if (sync_n == SD) begin
          // late half of the period: fire now rather than skip it
          if (cnt_n[CNT_W-1] && !pri_on && !int_n) begin
            int_n = 1'b1;
            src_n = 1'b0;
          end
          cnt_n = '0;
        end
      end

      if (line_hit && !int_n) begin
        int_n = 1'b1;
        src_n = 1'b1;
      end
    end

    if (vr)
      sync_n = 2'd0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      old_hs <= 1'b0;
      old_vs <= 1'b0;
      int_q  <= 1'b0;
      src_q  <= 1'b0;
      cnt_q  <= '0;
      sync_q <= SD;
    end else begin
      old_hs <= crtc_hs;
      old_vs <= crtc_vs;
      int_q  <= int_n;
      src_q  <= src_n;
      cnt_q  <= cnt_n;
      sync_q <= sync_n;
    end
  end

  assign bus.INT     = int_q;
  assign bus.INT_SRC = src_q;
  assign line_cnt    = cnt_q;

endmodule

// File: tb/tb_cpc_int_gen.sv
// Directed bench for cpc_int_gen: periodic, ack, resync,
// GA command, async reset and (when built) PRI.
module tb_cpc_int_gen;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       crtc_hs = 1'b0;
  logic       crtc_vs = 1'b0;
  logic [5:0] line_cnt;

  int passed = 0;
  int total  = 0;

  cpc_int_gen_if #(.LINE_W(8)) bus ();

  cpc_int_gen dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .crtc_hs  (crtc_hs),
    .crtc_vs  (crtc_vs),
    .bus      (bus),
    .line_cnt (line_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic hf();
    @(negedge CLK) crtc_hs = 1'b1;
    @(negedge CLK) crtc_hs = 1'b0;
    @(negedge CLK);
  endtask

  task automatic hfs(input int n);
    for (int i = 0; i < n; i++) hf();
  endtask

  task automatic vr();
    @(negedge CLK) crtc_vs = 1'b1;
    @(negedge CLK) crtc_vs = 1'b0;
  endtask

  task automatic ack();
    @(negedge CLK) bus.INTack = 1'b1;
    @(negedge CLK) bus.INTack = 1'b0;
  endtask

  task automatic ga_wr(input logic [7:0] d);
    @(negedge CLK) begin bus.WE = 1'b1; bus.D = d; end
    @(negedge CLK) begin bus.WE = 1'b0; bus.D = 8'h00; end
  endtask

  task automatic hf_with_wr(input logic [7:0] d);
    @(negedge CLK) crtc_hs = 1'b1;
    @(negedge CLK) begin
      crtc_hs = 1'b0; bus.WE = 1'b1; bus.D = d;
    end
    @(negedge CLK) begin bus.WE = 1'b0; bus.D = 8'h00; end
  endtask

  task automatic do_reset();
    @(negedge CLK) RESET = 1'b1;
    @(negedge CLK) RESET = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (bus.INT !== 1'b0)
      $display("FAIL reset_int got %b want 0", bus.INT);
    else passed++;
    total++;
    if (bus.INT_SRC !== 1'b0)
      $display("FAIL reset_src got %b want 0", bus.INT_SRC);
    else passed++;
    total++;
    if (line_cnt !== 6'd0)
      $display("FAIL reset_cnt got %0d want 0", line_cnt);
    else passed++;
  endtask

  task automatic test_periodic();
    do_reset();
    for (int i = 1; i <= 120; i++) begin
      hf();
      if (i == 51 || i == 103) begin
        total++;
        if (bus.INT !== 1'b0)
          $display("FAIL periodic_early_%0d got %b want 0", i, bus.INT);
        else passed++;
      end
      if (i == 52 || i == 104) begin
        total++;
        if (bus.INT !== 1'b1 || line_cnt !== 6'd0)
          $display("FAIL periodic_hf%0d got int=%b cnt=%0d want int=1 cnt=0",
                   i, bus.INT, line_cnt);
        else passed++;
        ack();
      end
    end
    total++;
    if (line_cnt !== 6'd16)
      $display("FAIL periodic_end_cnt got %0d want 16", line_cnt);
    else passed++;
  endtask

  task automatic test_ack();
    do_reset();
    hfs(52);
    hfs(40);
    total++;
    if (bus.INT !== 1'b1 || line_cnt !== 6'd40)
      $display("FAIL ack_pre got int=%b cnt=%0d want int=1 cnt=40",
               bus.INT, line_cnt);
    else passed++;
    ack();
    total++;
    if (bus.INT !== 1'b0 || line_cnt !== 6'd8)
      $display("FAIL ack_clear got int=%b cnt=%0d want int=0 cnt=8",
               bus.INT, line_cnt);
    else passed++;
    hfs(43);
    total++;
    if (bus.INT !== 1'b0 || line_cnt !== 6'd51)
      $display("FAIL ack_plus43 got int=%b cnt=%0d want int=0 cnt=51",
               bus.INT, line_cnt);
    else passed++;
    hf();
    total++;
    if (bus.INT !== 1'b1 || line_cnt !== 6'd0)
      $display("FAIL ack_plus44 got int=%b cnt=%0d want int=1 cnt=0",
               bus.INT, line_cnt);
    else passed++;
  endtask

  task automatic test_resync();
    do_reset();
    hfs(35);
    vr();
    hf();
    total++;
    if (bus.INT !== 1'b0 || line_cnt !== 6'd36)
      $display("FAIL resync_hf1 got int=%b cnt=%0d want int=0 cnt=36",
               bus.INT, line_cnt);
    else passed++;
    hf();
    total++;
    if (bus.INT !== 1'b1 || line_cnt !== 6'd0)
      $display("FAIL resync_hf2 got int=%b cnt=%0d want int=1 cnt=0",
               bus.INT, line_cnt);
    else passed++;
    ack();
    hfs(10);
    vr();
    hf();
    total++;
    if (line_cnt !== 6'd11)
      $display("FAIL resync_low_hf1 got cnt=%0d want 11", line_cnt);
    else passed++;
    hf();
    total++;
    if (bus.INT !== 1'b0 || line_cnt !== 6'd0)
      $display("FAIL resync_low_hf2 got int=%b cnt=%0d want int=0 cnt=0",
               bus.INT, line_cnt);
    else passed++;
    hf();
    total++;
    if (line_cnt !== 6'd1)
      $display("FAIL resync_idle got cnt=%0d want 1", line_cnt);
    else passed++;
  endtask

  task automatic test_ga_cmd();
    do_reset();
    hfs(52);
    hfs(5);
    hf_with_wr(8'h90);
    total++;
    if (bus.INT !== 1'b0 || line_cnt !== 6'd1)
      $display("FAIL ga_cmd_hf got int=%b cnt=%0d want int=0 cnt=1",
               bus.INT, line_cnt);
    else passed++;
    hfs(51);
    hfs(3);
    total++;
    if (bus.INT !== 1'b1 || line_cnt !== 6'd3)
      $display("FAIL ga_pre got int=%b cnt=%0d want int=1 cnt=3",
               bus.INT, line_cnt);
    else passed++;
    ga_wr(8'h80);
    total++;
    if (bus.INT !== 1'b1 || line_cnt !== 6'd3)
      $display("FAIL ga_80 got int=%b cnt=%0d want int=1 cnt=3",
               bus.INT, line_cnt);
    else passed++;
    ga_wr(8'hD0);
    total++;
    if (bus.INT !== 1'b1 || line_cnt !== 6'd3)
      $display("FAIL ga_d0 got int=%b cnt=%0d want int=1 cnt=3",
               bus.INT, line_cnt);
    else passed++;
    ga_wr(8'hB0);
    total++;
    if (bus.INT !== 1'b0 || line_cnt !== 6'd0)
      $display("FAIL ga_b0 got int=%b cnt=%0d want int=0 cnt=0",
               bus.INT, line_cnt);
    else passed++;
  endtask

  task automatic test_async_reset();
    do_reset();
    hfs(59);
    total++;
    if (bus.INT !== 1'b1 || line_cnt !== 6'd7)
      $display("FAIL areset_pre got int=%b cnt=%0d want int=1 cnt=7",
               bus.INT, line_cnt);
    else passed++;
    @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    total++;
    if (bus.INT !== 1'b0 || line_cnt !== 6'd0)
      $display("FAIL areset got int=%b cnt=%0d want int=0 cnt=0",
               bus.INT, line_cnt);
    else passed++;
    @(negedge CLK) RESET = 1'b0;
  endtask

`ifdef CPC_INT_PRI_EN
  task automatic test_pri();
    do_reset();
    @(negedge CLK) begin bus.PRI_WE = 1'b1; bus.PRI_D = 8'd100; end
    @(negedge CLK) begin bus.PRI_WE = 1'b0; bus.PRI_D = 8'd0; end
    vr();
    for (int i = 1; i <= 120; i++) begin
      hf();
      if (i == 52 || i == 54 || i == 99) begin
        total++;
        if (bus.INT !== 1'b0)
          $display("FAIL pri_none_%0d got %b want 0", i, bus.INT);
        else passed++;
      end
      if (i == 100) begin
        total++;
        if (bus.INT !== 1'b1 || bus.INT_SRC !== 1'b1 || line_cnt !== 6'd46)
          $display("FAIL pri_hit got int=%b src=%b cnt=%0d want 1 1 46",
                   bus.INT, bus.INT_SRC, line_cnt);
        else passed++;
        ack();
        total++;
        if (bus.INT !== 1'b0 || line_cnt !== 6'd46)
          $display("FAIL pri_ack got int=%b cnt=%0d want int=0 cnt=46",
                   bus.INT, line_cnt);
        else passed++;
      end
    end
    total++;
    if (bus.INT !== 1'b0)
      $display("FAIL pri_end got %b want 0", bus.INT);
    else passed++;
  endtask
`else
  task automatic test_pri();
    do_reset();
    @(negedge CLK) begin bus.PRI_WE = 1'b1; bus.PRI_D = 8'd5; end
    @(negedge CLK) begin bus.PRI_WE = 1'b0; bus.PRI_D = 8'd0; end
    hfs(52);
    total++;
    if (bus.INT !== 1'b1 || bus.INT_SRC !== 1'b0)
      $display("FAIL pri_ignored got int=%b src=%b want 1 0",
               bus.INT, bus.INT_SRC);
    else passed++;
  endtask
`endif

  initial begin
    bus.D      = 8'h00;
    bus.WE     = 1'b0;
    bus.PRI_WE = 1'b0;
    bus.PRI_D  = 8'h00;
    bus.INTack = 1'b0;
    test_reset();
    test_periodic();
    test_ack();
    test_resync();
    test_ga_cmd();
    test_async_reset();
    test_pri();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cpc_int_gen.md
# cpc_int_gen

Parametrised raster interrupt generator for the CPC video subsystem, successor to the gate-array interrupt logic. Counts CRTC HSYNC falling edges, raises the Z80 maskable interrupt every `LINES_PER_INT` lines, and resynchronises to VSYNC after `SYNC_DELAY` HSYNCs. It handles Z80 acknowledge and the gate-array counter-reset command. Optionally adds a CPC Plus–style programmable raster interrupt (PRI).

## Interface
- `LINES_PER_INT`, 52: HSYNC falling edges between periodic interrupts; 2..2^`CNT_W`-1.
- `CNT_W`, 6: line-counter width; the threshold bit is `CNT_W`-1.
- `SYNC_DELAY`, 2: HSYNC falling edges after VSYNC rise before resync; 1..3.
- `LINE_W`, 8: scanline-since-VSYNC counter width (PRI compare).

Ports:
- `CLK` in 1: system clock.
- `RESET` in 1: asynchronous, active-high reset.
- `crtc_hs` in 1: CRTC HSYNC, synchronous to `CLK`.
- `crtc_vs` in 1: CRTC VSYNC, synchronous to `CLK`.
- `INTack` in 1: one-cycle Z80 interrupt acknowledge.
- `D` in 8: CPU write data to the gate array.
- `WE` in 1: one-cycle gate-array write strobe.
- `PRI_WE` in 1: one-cycle PRI register write strobe (PRI build only; otherwise ignored).
- `PRI_D` in `LINE_W`: PRI register data.
- `INT` out 1: interrupt request, registered.
- `INT_SRC` out 1: source of the current request; 0 = periodic, 1 = PRI.
- `line_cnt` out `CNT_W`: current periodic line counter, for debug.

## Operation
- **Edge detect.** `old_hs` and `old_vs` are registered every `CLK`.
  - HSYNC fall (HF) = `old_hs & ~crtc_hs`.
  - VSYNC rise (VR) = `~old_vs & crtc_vs`.
- **Periodic counter (`cnt`).**
  - On HF, `cnt` increments.
  - If the result equals `LINES_PER_INT`, `cnt` becomes 0 and `INT` is set with `INT_SRC` = 0.
- **Resync (`sync`, 2 bits).**
  - VR sets `sync` = 0.
  - On each HF while `sync` < `SYNC_DELAY`, `sync` increments.
  - When it reaches `SYNC_DELAY`: if `cnt[CNT_W-1]` is set after the increment, `INT` is set with `INT_SRC` = 0; `cnt` is then cleared.
  - `sync` == `SYNC_DELAY` is idle.
- **Acknowledge.** `INTack` clears `INT`. If `INT_SRC` = 0, it also clears `cnt[CNT_W-1]`.
- **GA command.** `WE` with `D[7:6]`=2'b10 and `D[4]`=1 clears `cnt` and `INT`. Other `WE` values are ignored.
- **Evaluation order within one cycle:** ack → GA command → HF increment and compare → resync → VR.
  - Consequences: command + HF leaves `cnt` = 1; ack + new set leaves `INT` = 1; VR + HF processes HF, then `sync` = 0.
- **Reset values.** All state is cleared asynchronously:
  - `INT` = 0, `INT_SRC` = 0, `cnt` = 0.
  - `sync` = `SYNC_DELAY`, `old_hs` = `old_vs` = 0.
  - Scanline counter = 0, PRI register = 0.

## Timing
- `INT` rises on the `CLK` edge that samples the HF/VR condition. It is visible 1 cycle after the first low sample of `crtc_hs`.
- Ack and GA command take effect on the same edge as the strobe.
- `INT` holds until cleared; repeat sets while high are no-ops.
- `cnt` wraps only through the `LINES_PER_INT` compare. It never exceeds `LINES_PER_INT`-1 after an edge.

## Configuration
- `CPC_INT_PRI_EN` defined:
  - PRI register written by `PRI_WE`.
  - Scanline counter: cleared on VR, incremented on HF, saturating at all ones.
  - When PRI ≠ 0:
    - Periodic and resync interrupt sets are suppressed; `cnt` and `sync` still run.
    - HF with post-increment scanline == PRI sets `INT` with `INT_SRC` = 1.
  - PRI = 0 gives exact periodic behaviour.
- `CPC_INT_PRI_EN` undefined:
  - No PRI register or scanline counter is built.
  - `PRI_WE` and `PRI_D` are ignored; `INT_SRC` is tied to 0.

## Test plan
- **Periodic.** Defaults, 120 HF pulses, no VSYNC → `INT` rises on HF #52 and #104; `cnt` = 0 at each.
- **Ack.** `INT` high, `INTack` pulse at `cnt` = 40 → `INT` = 0 and `cnt` = 8 on the next edge; next `INT` at +44 HF.
- **Resync.** VR at `cnt` = 35, then 2 HF → `INT` on the 2nd HF (cnt 37 ≥ 32), `cnt` = 0. Repeat VR at `cnt` = 10 → no `INT`, `cnt` = 0.
- **GA command.** `WE`, `D`=8'h90 coincident with HF while `INT` = 1 → `INT` = 0, `cnt` = 1. `D`=8'h80 → no effect.
- **Async reset.** `RESET` mid-count with `INT` high → `INT` = 0 and `cnt` = 0 immediately, without a `CLK` edge.
- **PRI (`CPC_INT_PRI_EN`).** PRI = 100, VR, 120 HF → single `INT` at HF #100 with `INT_SRC` = 1, none at #52. Ack leaves `cnt` unchanged.
